layer1_controller: RTL and testbench
====================================

LAYER1_CONTROLLER -- requirements
Module: layer1_controller

Interface
REQ-001 The block SHALL have parameter RELU_EN, default 1; 1 clamps negative channel results to 0, 0 passes them through.
REQ-002 The block SHALL have parameter CNT_W, default 16; this is the width of the pixel count and of the internal counters.
REQ-003 The block SHALL have these ports, with clock and reset first:
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  job start request; sampled only in IDLE.
- reload_w  in  1  with start, load 8 new weight vectors before running.
- pixel_num  in  CNT_W  pixels in the job; latched at start.
- w_valid / w_ready  in / out  1 / 1  weight-load handshake.
- w_data  in  48  one weight vector as three Q5.10 words, [47:32],[31:16],[15:0].
- in_valid / in_ready  in / out  1 / 1  pixel-input handshake.
- in_data  in  48  one pixel as three Q5.10 channels, same packing as w_data.
- dp_input_channel  out  48  to the datapath input.
- dp_weight  out  384  to the datapath; weight vector n (1..8) at [48n-1:48(n-1)].
- dp_out  in  128  combinational datapath result; channel n at [16n-1:16(n-1)].
- out_valid / out_ready  out / in  1 / 1  result handshake.
- out_data  out  128  registered result, same packing as dp_out.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse at job completion.

Function
REQ-004 The FSM SHALL have exactly four states: IDLE, LOAD_W, RUN, DONE.
REQ-005 In IDLE, when start=1, the block SHALL latch pixel_num and move to LOAD_W if reload_w=1, otherwise to RUN.
REQ-006 In LOAD_W, w_ready SHALL be 1 and each w_valid&w_ready beat SHALL write weight vector 1, 2, …, 8 in order, driven by a 3-bit index starting at 0.
REQ-007 After the 8th beat, the FSM SHALL go to RUN on the next edge, and w_ready SHALL be 0 outside LOAD_W.
REQ-008 Weight registers SHALL hold their values across jobs and SHALL drive dp_weight continuously.
REQ-009 The pipeline SHALL have two stages: an input register (in_reg, in_reg_v) driving dp_input_channel, then an output register (out_data, out_valid) capturing dp_out.
REQ-010 Pipeline advance SHALL be defined as adv = !out_valid | out_ready.
REQ-011 in_ready SHALL equal (state==RUN) & (in_cnt<pixel_num_latched) & (!in_reg_v | adv).
REQ-012 On an input handshake, in_reg SHALL load in_data, in_reg_v SHALL be set, and in_cnt SHALL increment.
REQ-013 When adv=1 and in_reg_v=1, the output register SHALL load the post-processed dp_out and set out_valid.
REQ-014 When adv=1 and no new input is accepted, in_reg_v SHALL clear.
REQ-015 When out_valid=1 and out_ready=1 and in_reg_v=0, out_valid SHALL clear.
REQ-016 Latency: a pixel accepted at edge k SHALL appear on out_data with out_valid=1 after edge k+1, assuming no back-pressure.
REQ-017 Sustained throughput SHALL be one pixel per cycle while out_ready=1.
REQ-018 While out_valid=1 and out_ready=0, out_data and out_valid SHALL remain stable, and no accepted pixel SHALL be lost or duplicated.
REQ-019 Post-processing SHALL work on each 16-bit signed channel independently: if RELU_EN=1 and the value is negative, the result is 0x0000; otherwise the value is unchanged.
REQ-020 out_cnt SHALL increment on each out_valid&out_ready handshake.
REQ-021 The FSM SHALL leave RUN for DONE on the handshake that makes out_cnt equal to pixel_num_latched.
REQ-022 If pixel_num_latched=0, RUN SHALL go to DONE on the next edge with no input accepted.
REQ-023 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-024 in_cnt, out_cnt and the weight index SHALL be cleared on entry to RUN or LOAD_W.
REQ-025 start SHALL be ignored in every state except IDLE.
REQ-026 Input handshakes SHALL be ignored outside RUN, since in_ready=0 there.
REQ-027 Weight handshakes SHALL be ignored outside LOAD_W, since w_ready=0 there.

Reset
REQ-028 While rst=1, the block SHALL asynchronously force: state=IDLE; all weight registers, in_reg and out_data = 0; in_reg_v, out_valid, w_ready, in_ready, busy and done = 0; all counters = 0.
REQ-029 A reset asserted in the middle of a job SHALL abort it with no done pulse; the block SHALL restart only on a new start after rst falls.

Verification
REQ-030 Scenario: start with reload_w=1 and pixel_num=1; load all 8 weights = {0x0400,0x0400,0x0400}; input {0x0400,0x0800,0xFE00} -> every channel of out_data = 0x0A00 two edges after acceptance; done pulses once.
REQ-031 Scenario: RELU_EN=1, weight vector 3 = {0xFC00,0xFC00,0xFC00}, same input -> channel 3 = 0x0000 and the other channels = 0x0A00; with RELU_EN=0, channel 3 = 0xF600.
REQ-032 Scenario: pixel_num=4, in_valid held high, out_ready=1 -> 4 consecutive out_valid cycles; done pulses 1 cycle after the 4th handshake.
REQ-033 Scenario: out_ready=0 for 5 cycles during a pixel_num=6 stream -> in_ready drops after the pipeline fills; all 6 results are delivered in order with no duplicates.
REQ-034 Scenario: start with pixel_num=0 -> done pulses 2 cycles after start; in_ready is never 1.
REQ-035 Scenario: assert rst after the 5th weight beat -> all outputs 0 immediately; a following start with reload_w=0 uses all-zero weights, so out_data = 0.

Source files
------------

// File: rtl/layer1_controller.sv
// Layer-1 controller: loads 8 weight vectors, streams pixels through an external datapath, applies ReLU.
// Latency: a pixel accepted at edge k is on out_data after edge k+1; one pixel per cycle sustained.
// Backpressure: out_ready low freezes out_data/out_valid; in_ready drops once the input register cannot drain.
module layer1_controller #(
    parameter int RELU_EN = 1,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             reload_w,
    input  logic [CNT_W-1:0] pixel_num,
    input  logic             w_valid,
    output logic             w_ready,
    input  logic [47:0]      w_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [47:0]      in_data,
    output logic [47:0]      dp_input_channel,
    output logic [383:0]     dp_weight,
    input  logic [127:0]     dp_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [127:0]     out_data,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {IDLE, LOAD_W, RUN, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] pixel_num_latched;
    logic [CNT_W-1:0] in_cnt;
    logic [CNT_W-1:0] out_cnt;
    logic [2:0]       w_idx;
    logic [7:0][47:0] w_reg;
    logic [47:0]      in_reg;
    logic             in_reg_v;

    logic             adv;
    logic             in_fire;
    logic             out_fire;
    logic             w_fire;
    logic             last_out;
    logic [127:0]     post;

    assign adv      = !out_valid | out_ready;
    assign in_ready = (state == RUN) & (in_cnt < pixel_num_latched) & (!in_reg_v | adv);
    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;
    assign w_fire   = w_valid & w_ready;
    assign last_out = out_fire & ((out_cnt + CNT_W'(1)) == pixel_num_latched);

    assign dp_input_channel = in_reg;
    assign dp_weight        = w_reg;

    // Each 16-bit channel is clamped on its own sign bit.
    always_comb begin
        post = dp_out;
        for (int n = 0; n < 8; n++) begin
            if (RELU_EN != 0 && dp_out[16*n+15]) begin
                post[16*n +: 16] = 16'h0000;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= IDLE;
            pixel_num_latched <= '0;
            in_cnt            <= '0;
            out_cnt           <= '0;
            w_idx             <= '0;
            w_reg             <= '0;
            w_ready           <= 1'b0;
            busy              <= 1'b0;
            done              <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        pixel_num_latched <= pixel_num;
                        in_cnt            <= '0;
                        out_cnt           <= '0;
                        w_idx             <= '0;
                        busy              <= 1'b1;
                        if (reload_w) begin
                            state   <= LOAD_W;
                            w_ready <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                LOAD_W: begin
                    if (w_fire) begin
                        w_reg[w_idx] <= w_data;
                        w_idx        <= w_idx + 3'd1;
                        if (w_idx == 3'd7) begin
                            state   <= RUN;
                            w_ready <= 1'b0;
                            in_cnt  <= '0;
                            out_cnt <= '0;
                        end
                    end
                end
                RUN: begin
                    if (in_fire) begin
                        in_cnt <= in_cnt + CNT_W'(1);
                    end
                    if (out_fire) begin
                        out_cnt <= out_cnt + CNT_W'(1);
                    end
                    // An empty job finishes straight away; otherwise on the final result handshake.
                    if (pixel_num_latched == '0 || last_out) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Two-stage pipeline; the input register only empties when the output stage can take it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_reg    <= '0;
            in_reg_v  <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            if (in_fire) begin
                in_reg   <= in_data;
                in_reg_v <= 1'b1;
            end else if (adv) begin
                in_reg_v <= 1'b0;
            end

            if (adv && in_reg_v) begin
                out_data  <= post;
                out_valid <= 1'b1;
            end else if (out_fire) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_layer1_controller.sv
// Bench for layer1_controller: directed scenarios plus randomized jobs against a dot-product/ReLU model.
module tb_layer1_controller;

    localparam int           CNT_W    = 16;
    localparam logic [127:0] ALL_0A00 = {8{16'h0A00}};
    localparam logic [127:0] CH3_ZERO = 128'h0A00_0A00_0A00_0A00_0A00_0000_0A00_0A00;
    localparam logic [127:0] CH3_NEG  = 128'h0A00_0A00_0A00_0A00_0A00_F600_0A00_0A00;
    localparam logic [47:0]  PX_FIX   = 48'h0400_0800_FE00;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             reload_w;
    logic [CNT_W-1:0] pixel_num;
    logic             w_valid;
    logic [47:0]      w_data;
    logic             in_valid;
    logic [47:0]      in_data;
    logic             out_ready;

    logic             w_ready, in_ready, out_valid, busy, done;
    logic [47:0]      dp_in;
    logic [383:0]     dp_w;
    logic [127:0]     dp_out, out_data;

    logic             w_ready_n, in_ready_n, out_valid_n, busy_n, done_n;
    logic [47:0]      dp_in_n;
    logic [383:0]     dp_w_n;
    logic [127:0]     dp_out_n, out_data_n;

    logic [383:0]     wm;
    int               n_pass = 0;
    int               n_chk  = 0;

    always #5 clk = ~clk;

    // Q5.10 dot product of a pixel with each weight vector, optional ReLU.
    function automatic logic [127:0] dp_ref(input logic [47:0] px, input logic [383:0] w, input bit relu);
        logic [127:0] r;
        longint       acc;
        r = '0;
        for (int n = 0; n < 8; n++) begin
            acc = 0;
            for (int c = 0; c < 3; c++) begin
                acc += longint'($signed(px[16*c +: 16])) * longint'($signed(w[48*n + 16*c +: 16]));
            end
            acc = acc >>> 10;
            r[16*n +: 16] = (relu && acc[15]) ? 16'h0000 : acc[15:0];
        end
        return r;
    endfunction

    assign dp_out   = dp_ref(dp_in, dp_w, 1'b0);
    assign dp_out_n = dp_ref(dp_in_n, dp_w_n, 1'b0);

    layer1_controller #(.RELU_EN(1), .CNT_W(CNT_W)) u_dut (
        .clk(clk), .rst(rst), .start(start), .reload_w(reload_w), .pixel_num(pixel_num),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .dp_input_channel(dp_in), .dp_weight(dp_w), .dp_out(dp_out),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .done(done)
    );

    layer1_controller #(.RELU_EN(0), .CNT_W(CNT_W)) u_dut_nr (
        .clk(clk), .rst(rst), .start(start), .reload_w(reload_w), .pixel_num(pixel_num),
        .w_valid(w_valid), .w_ready(w_ready_n), .w_data(w_data),
        .in_valid(in_valid), .in_ready(in_ready_n), .in_data(in_data),
        .dp_input_channel(dp_in_n), .dp_weight(dp_w_n), .dp_out(dp_out_n),
        .out_valid(out_valid_n), .out_ready(out_ready), .out_data(out_data_n),
        .busy(busy_n), .done(done_n)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_w_ready", w_ready, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_dp_weight_nonzero", |dp_w, 0);
        chk("rst_dp_input", dp_in, 0);
    endtask

    task automatic do_start(input bit reload, input int pn);
        start     = 1'b1;
        reload_w  = reload;
        pixel_num = CNT_W'(pn);
        tick();
        start    = 1'b0;
        reload_w = 1'b0;
        chk("busy_after_start", busy, 1);
    endtask

    task automatic load_weights(input logic [383:0] w, input int nbeats);
        int beat = 0;
        int cyc  = 0;
        while (beat < nbeats && cyc < 200) begin
            w_valid = ($urandom_range(0, 3) != 0);
            w_data  = w[48*beat +: 48];
            @(negedge clk);
            chk("w_ready_in_load", w_ready, 1);
            if (w_valid && w_ready) begin
                wm[48*beat +: 48] = w[48*beat +: 48];
                beat++;
            end
            tick();
            cyc++;
        end
        w_valid = 1'b0;
        chk("w_beats_loaded", beat, nbeats);
        if (nbeats == 8) chk("w_ready_after_load", w_ready, 0);
    endtask

    task automatic stream(input int pn, input int vprob, input int rprob,
                          input int stall_at, input int stall_len,
                          input bit use_fix, input logic [47:0] fix_px,
                          output int done_cyc, output int first_in, output int first_out,
                          output int last_out, output bit stall_drop,
                          output logic [127:0] last_dat, output logic [127:0] last_dat_nr);
        logic [47:0]  q[$];
        logic [47:0]  px;
        logic [127:0] prev_dat;
        bit           prev_hold = 0;
        bit           extra_rdy = 0;
        int           sent = 0, got = 0, dones = 0, spurious = 0;
        done_cyc = -1; first_in = -1; first_out = -1; last_out = -1;
        stall_drop = 0; last_dat = '0; last_dat_nr = '0; prev_dat = '0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            in_valid  = (sent < pn) && ($urandom_range(0, 99) < vprob);
            in_data   = use_fix ? fix_px : {16'($urandom), 16'($urandom), 16'($urandom)};
            out_ready = (cyc >= stall_at && cyc < stall_at + stall_len) ? 1'b0
                                                                        : ($urandom_range(0, 99) < rprob);
            start     = ($urandom_range(0, 7) == 0);
            reload_w  = 1'($urandom_range(0, 1));
            w_valid   = ($urandom_range(0, 3) == 0);
            w_data    = {16'($urandom), 16'($urandom), 16'($urandom)};
            @(negedge clk);
            if (prev_hold) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", out_data, prev_dat);
            end
            if (sent >= pn && in_ready) extra_rdy = 1;
            if (out_valid && !out_ready && !in_ready && sent < pn) stall_drop = 1;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    spurious++;
                end else begin
                    px = q.pop_front();
                    chk("out_data_relu", out_data, dp_ref(px, wm, 1'b1));
                    chk("out_data_norelu", out_data_n, dp_ref(px, wm, 1'b0));
                    last_dat    = out_data;
                    last_dat_nr = out_data_n;
                end
                if (first_out < 0) first_out = cyc;
                last_out = cyc;
                got++;
            end
            if (in_valid && in_ready) begin
                q.push_back(in_data);
                sent++;
                if (first_in < 0) first_in = cyc;
            end
            if (done) begin
                dones++;
                done_cyc = cyc;
                break;
            end
            prev_hold = out_valid && !out_ready;
            prev_dat  = out_data;
            tick();
        end
        start = 1'b0; reload_w = 1'b0; in_valid = 1'b0; w_valid = 1'b0; out_ready = 1'b1;
        chk("job_done_seen", dones, 1);
        chk("outputs_delivered", got, pn);
        chk("no_spurious_output", spurious, 0);
        chk("queue_drained", q.size(), 0);
        chk("in_ready_past_count", extra_rdy, 0);
        if (dones == 1) chk("done_after_last_hs", done_cyc, (pn == 0) ? 1 : last_out + 1);
        tick();
        chk("done_one_cycle", done, 0);
        chk("busy_back_idle", busy, 0);
    endtask

    initial begin
        logic [383:0] w;
        logic [127:0] ld, ldn;
        int           dc, fi, fo, lo, pn;
        bit           sd, rl;

        rst = 1'b1; start = 1'b0; reload_w = 1'b0; pixel_num = '0;
        w_valid = 1'b0; w_data = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        wm = '0;
        #12;
        chk_reset_outputs();
        tick();
        rst = 1'b0;
        tick();

        // Unit weights, fixed pixel -> 2.5 on every channel.
        w = {8{48'h0400_0400_0400}};
        do_start(1'b1, 1);
        load_weights(w, 8);
        stream(1, 100, 100, 0, 0, 1'b1, PX_FIX, dc, fi, fo, lo, sd, ld, ldn);
        chk("s1_relu_result", ld, ALL_0A00);
        chk("s1_norelu_result", ldn, ALL_0A00);
        chk("s1_latency", fo - fi, 2);

        // Negative weight vector 3 exercises the clamp.
        w[48*2 +: 48] = 48'hFC00_FC00_FC00;
        do_start(1'b1, 1);
        load_weights(w, 8);
        stream(1, 100, 100, 0, 0, 1'b1, PX_FIX, dc, fi, fo, lo, sd, ld, ldn);
        chk("s2_relu_ch3", ld, CH3_ZERO);
        chk("s2_norelu_ch3", ldn, CH3_NEG);

        // Full-rate stream of 4 pixels, weights kept from the previous job.
        do_start(1'b0, 4);
        stream(4, 100, 100, 0, 0, 1'b0, '0, dc, fi, fo, lo, sd, ld, ldn);
        chk("s3_consecutive_out", lo - fo, 3);
        chk("s3_latency", fo - fi, 2);

        // Five-cycle output stall in the middle of 6 pixels.
        do_start(1'b0, 6);
        stream(6, 100, 100, 3, 5, 1'b0, '0, dc, fi, fo, lo, sd, ld, ldn);
        chk("s4_in_ready_dropped", sd, 1);

        // Empty job.
        do_start(1'b0, 0);
        stream(0, 100, 100, 0, 0, 1'b0, '0, dc, fi, fo, lo, sd, ld, ldn);
        chk("s5_done_cycle", dc, 1);

        // Randomized jobs with random weights, throttling and stalls.
        for (int j = 0; j < 5; j++) begin
            rl = (j == 0) || ($urandom_range(0, 1) == 1);
            pn = $urandom_range(1, 12);
            for (int i = 0; i < 12; i++) w[32*i +: 32] = $urandom;
            do_start(rl, pn);
            if (rl) load_weights(w, 8);
            stream(pn, $urandom_range(30, 100), $urandom_range(30, 100),
                   $urandom_range(0, 10), $urandom_range(0, 6), 1'b0, '0,
                   dc, fi, fo, lo, sd, ld, ldn);
        end

        // Reset after the 5th weight beat aborts the job and clears the weights.
        for (int i = 0; i < 12; i++) w[32*i +: 32] = $urandom | 32'h0001_0001;
        do_start(1'b1, 3);
        load_weights(w, 5);
        rst = 1'b1;
        #1;
        chk_reset_outputs();
        wm = '0;
        tick();
        chk("rst_no_done", done, 0);
        rst = 1'b0;
        tick();
        chk("rst_stays_idle", busy, 0);
        do_start(1'b0, 3);
        stream(3, 100, 100, 0, 0, 1'b1, PX_FIX, dc, fi, fo, lo, sd, ld, ldn);
        chk("s6_zero_weights_out", ld, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
